// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD block-channel arbiter.
package sd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Slot index equals the host SD slot number.
  localparam int SLOT_FDD1 = 0;
  localparam int SLOT_HDD  = 1;
  localparam int SLOT_FDD2 = 2;

  // One second at 14 MHz.
  localparam int DEFAULT_TIMEOUT = 14_000_000;

  localparam int CNT_W = 24;

endpackage

// File: rtl/sd_arb_rr.sv
// Round-robin picker: grants the first pending slot after the last served one.
module sd_arb_rr #(
  parameter int NCH = 3,
  parameter int LW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] pend,
  input  logic [LW-1:0]  last,
  output logic [NCH-1:0] grant,
  output logic           any
);

  logic          found;
  logic [LW-1:0] idx;

  // Walk slots last+1, last+2, ... wrapping; the first pending one wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = LW'((int'(last) + k) % NCH);
      if (!found && pend[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any = |pend;

endmodule

// File: rtl/sd_arbiter.sv
// Serializes per-slot block requests onto the shared SD host channel.
module sd_arbiter
  import sd_arb_pkg::*;
#(
  parameter int             NCH       = 3,
  parameter logic [NCH-1:0] WAIT_MASK = 3'b010,
  parameter int             TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [NCH-1:0]        req_rd,
  input  logic [NCH-1:0]        req_wr,
  input  logic [NCH-1:0][31:0]  req_lba,
  output logic [NCH-1:0]        done,
  output logic [NCH-1:0]        err,
  output logic [NCH-1:0]        busy,
  output logic                  cpu_wait,
  output logic [NCH-1:0][31:0]  sd_lba,
  output logic [NCH-1:0]        sd_rd,
  output logic [NCH-1:0]        sd_wr,
  input  logic [NCH-1:0]        sd_ack,
  input  logic                  sd_buff_wr,
  output logic [NCH-1:0]        buff_wr
);

  localparam int               LW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [LW-1:0]    slot, last, gnt_idx;
  logic             dir_wr;
  logic [NCH-1:0]   pend_rd, pend_wr, pend_any, gnt;
  logic [NCH-1:0]   ack_s, old_ack;
  logic [NCH-1:0]   clr_rd, clr_wr, err_set, active;
  logic             gnt_any, ack_rise, ack_fall, timeout_hit;
  logic             grant_now, release_now;
  logic [CNT_W-1:0] cnt;

  assign pend_any = pend_rd | pend_wr;

  sd_arb_rr #(.NCH(NCH), .LW(LW)) u_rr (
    .pend  (pend_any),
    .last  (last),
    .grant (gnt),
    .any   (gnt_any)
  );

  // Turn the one-hot grant into a slot number.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) gnt_idx = LW'(i);
    end
  end

  // Ack edges are taken from the registered ack history, one cycle behind the pin.
  assign ack_rise    = ~old_ack[slot] & ack_s[slot];
  assign ack_fall    = old_ack[slot] & ~ack_s[slot];
  assign timeout_hit = (cnt == CNT_LAST);

  // Next-state and host strobes; only the active slot ever sees a strobe or buff_wr.
  always_comb begin
    state_nxt = state;
    sd_rd     = '0;
    sd_wr     = '0;
    buff_wr   = '0;
    done      = '0;
    clr_rd    = '0;
    clr_wr    = '0;
    err_set   = '0;
    case (state)
      IDLE: begin
        if (gnt_any && (sd_ack == '0)) state_nxt = ISSUE;
      end
      ISSUE: begin
        sd_rd[slot] = ~dir_wr;
        sd_wr[slot] = dir_wr;
        if (ack_rise) begin
          state_nxt = XFER;
        end else if (timeout_hit) begin
          state_nxt     = IDLE;
          err_set[slot] = 1'b1;
          clr_rd[slot]  = 1'b1;
          clr_wr[slot]  = 1'b1;
        end
      end
      XFER: begin
        buff_wr[slot] = sd_buff_wr & sd_ack[slot];
        if (ack_fall) state_nxt = DONE;
      end
      DONE: begin
        done[slot] = 1'b1;
        if (dir_wr) clr_wr[slot] = 1'b1;
        else        clr_rd[slot] = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign grant_now   = (state == IDLE) && (state_nxt == ISSUE);
  assign release_now = (state == DONE) || ((state == ISSUE) && (state_nxt == IDLE));

  // The granted slot counts as busy until the arbiter is back in IDLE.
  always_comb begin
    active = '0;
    if (state != IDLE) active[slot] = 1'b1;
  end

  assign busy     = pend_any | active;
  assign cpu_wait = |(busy & WAIT_MASK);

  // FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Latch slot, direction (write wins) and LBA at grant; remember who was served last.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      slot   <= '0;
      last   <= LW'(NCH - 1);
      dir_wr <= 1'b0;
      sd_lba <= '0;
    end else begin
      if (grant_now) begin
        slot            <= gnt_idx;
        dir_wr          <= pend_wr[gnt_idx];
        sd_lba[gnt_idx] <= req_lba[gnt_idx];
      end
      if (release_now) last <= slot;
    end
  end

  // Timeout counter restarts at each grant and saturates instead of wrapping.
  always_ff @(posedge clk_sys) begin
    if (reset)                                    cnt <= '0;
    else if (grant_now)                           cnt <= '0;
    else if ((state == ISSUE) && (cnt != CNT_MAX)) cnt <= cnt + CNT_W'(1);
  end

  // Sticky pending bits; a new request wins over the clear in the same cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_rd <= '0;
      pend_wr <= '0;
    end else begin
      pend_rd <= (pend_rd & ~clr_rd) | req_rd;
      pend_wr <= (pend_wr & ~clr_wr) | req_wr;
    end
  end

  // Ack history for edge detection and the registered abort pulse.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ack_s   <= '0;
      old_ack <= '0;
      err     <= '0;
    end else begin
      ack_s   <= sd_ack;
      old_ack <= ack_s;
      err     <= err_set;
    end
  end

endmodule
